// File: rtl/sargantana_icache_way_seq_if.sv
// Request/response and SRAM-side signal bundle for one icache way sequencer.
interface sargantana_icache_way_seq_if #(
    parameter int unsigned SET_WIDHT  = 32 * 8,
    parameter int unsigned ADDR_WIDHT = 6
);
    logic                  flush_i;
    logic                  fill_valid_i;
    logic                  fill_ready_o;
    logic [ADDR_WIDHT-1:0] fill_addr_i;
    logic [SET_WIDHT-1:0]  fill_data_i;
    logic                  rd_valid_i;
    logic                  rd_ready_o;
    logic [ADDR_WIDHT-1:0] rd_addr_i;
    logic                  rsp_valid_o;
    logic [SET_WIDHT-1:0]  rsp_data_o;
    logic                  busy_o;
    logic                  sram_req_o;
    logic                  sram_we_o;
    logic [ADDR_WIDHT-1:0] sram_addr_o;
    logic [SET_WIDHT-1:0]  sram_data_o;
    logic [SET_WIDHT-1:0]  sram_data_i;

    // Sequencer side
    modport slave (
        input  flush_i, fill_valid_i, fill_addr_i, fill_data_i,
        input  rd_valid_i, rd_addr_i, sram_data_i,
        output fill_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o, busy_o,
        output sram_req_o, sram_we_o, sram_addr_o, sram_data_o
    );

    // Controller / SRAM side
    modport master (
        output flush_i, fill_valid_i, fill_addr_i, fill_data_i,
        output rd_valid_i, rd_addr_i, sram_data_i,
        input  fill_ready_o, rd_ready_o, rsp_valid_o, rsp_data_o, busy_o,
        input  sram_req_o, sram_we_o, sram_addr_o, sram_data_o
    );
endinterface

// File: rtl/sargantana_icache_way_seq.sv
// Sequencer for one single-port icache way SRAM: clears all sets after reset or
// flush, then arbitrates fills over lookups and returns read data a cycle later.
module sargantana_icache_way_seq #(
    parameter int unsigned SET_WIDHT  = 32 * 8,
    parameter int unsigned ADDR_WIDHT = 6
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    sargantana_icache_way_seq_if.slave   bus
);
    localparam int unsigned NUM_SETS = 2 ** ADDR_WIDHT;
    localparam logic [ADDR_WIDHT-1:0] LAST_SET = ADDR_WIDHT'(NUM_SETS - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_SWEEP = 2'd1,
        ST_IDLE  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDHT-1:0] cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  fill_hs_c;
    logic                  rd_hs_c;

    // State, sweep counter and response-valid registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next state: sweep sequencing and flush restart
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rd_hs_c;
        case (state_q)
            ST_RESET: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
            ST_SWEEP: begin
                if (bus.flush_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_SET) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDHT'(1);
                end
            end
            ST_IDLE: begin
                if (bus.flush_i) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: handshakes, SRAM drive (same cycle as acceptance), response
    always_comb begin
        bus.busy_o       = (state_q != ST_IDLE);
        bus.fill_ready_o = (state_q == ST_IDLE) && !bus.flush_i;
        bus.rd_ready_o   = (state_q == ST_IDLE) && !bus.flush_i && !bus.fill_valid_i;
        fill_hs_c        = bus.fill_valid_i && bus.fill_ready_o;
        rd_hs_c          = bus.rd_valid_i && bus.rd_ready_o;
        bus.sram_req_o   = 1'b0;
        bus.sram_we_o    = 1'b0;
        bus.sram_addr_o  = '0;
        bus.sram_data_o  = '0;
        case (state_q)
            ST_SWEEP: begin
                bus.sram_req_o  = 1'b1;
                bus.sram_we_o   = 1'b1;
                bus.sram_addr_o = cnt_q;
            end
            ST_IDLE: begin
                if (fill_hs_c) begin
                    bus.sram_req_o  = 1'b1;
                    bus.sram_we_o   = 1'b1;
                    bus.sram_addr_o = bus.fill_addr_i;
                    bus.sram_data_o = bus.fill_data_i;
                end else if (rd_hs_c) begin
                    bus.sram_req_o  = 1'b1;
                    bus.sram_addr_o = bus.rd_addr_i;
                end
            end
            default: ;
        endcase
        bus.rsp_valid_o = rsp_valid_q;
        bus.rsp_data_o  = rsp_valid_q ? bus.sram_data_i : '0;
    end
endmodule
